ifetch: RTL
===========

IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter: RV, 32, register/address width.
REQ-002 Parameter: RESET_VEC, 0, PC loaded on reset; bit 0 ignored.
REQ-003 clk  input  1  sole clock; all state updates on posedge.
REQ-004 reset  input  1  synchronous reset, active-low (0 = in reset).
REQ-005 stall  input  1  downstream cannot accept a parcel this cycle.
REQ-006 pc_load  input  1  redirect (branch/jump/trap) strobe.
REQ-007 pc_new  input  RV  redirect target, halfword aligned; bit 0 ignored.
REQ-008 mem_req  output  1  instruction-word read request.
REQ-009 mem_addr  output  RV  word address of request; bits [1:0] always 0.
REQ-010 mem_ack  input  1  read complete; mem_rdata valid this cycle.
REQ-011 mem_rdata  input  32  read data; low half = lower halfword address.
REQ-012 ins  output  16  head parcel presented to decoder.
REQ-013 idone  output  1  ins valid and consumed this cycle (decoder capture strobe).
REQ-014 ins_pc  output  RV  halfword address of ins.

Function
REQ-015 Parcel queue SHALL hold 4 x 16-bit entries with count 0..4, circular head/tail pointers wrapping mod 4.
REQ-016 idone SHALL be high iff count>=1 and stall=0 and pc_load=0, combinational from registered state.
REQ-017 When idone is high the head SHALL pop at the clock edge; ins/ins_pc SHALL hold their value while stall=1.
REQ-018 ins_pc SHALL advance by 2 per pop, wrapping modulo 2^RV.
REQ-019 States: IDLE (no request outstanding), WAIT (request outstanding, data kept), KILL (request outstanding, data discarded).
REQ-020 IDLE->WAIT when a request is issued; WAIT->IDLE on mem_ack (or ->WAIT if a new request issues same edge); WAIT->KILL on pc_load without mem_ack; KILL->IDLE on mem_ack.
REQ-021 Once asserted, mem_req and mem_addr SHALL stay constant until mem_ack, even across pc_load.
REQ-022 Fetch address register SHALL advance by 4 on each kept mem_ack, wrapping modulo 2^RV.
REQ-023 On kept mem_ack, both halves SHALL be enqueued (low first) with count+=2, except the first word after an odd-halfword redirect, which enqueues only the high half (count+=1).
REQ-024 Pop and enqueue in the same cycle SHALL both take effect (count += enq - 1).
REQ-025 pc_load SHALL empty the queue, set ins_pc=pc_new and fetch address={pc_new[RV-1:2],2'b00}, and beat any same-cycle pop or mem_ack (that data discarded).
REQ-026 After pc_load in IDLE, mem_req SHALL assert on the next cycle with the new address.
REQ-027 Queue SHALL never overflow: a request is issued only when the slots free after any outstanding data are >=2.

Reset
REQ-028 While reset=0: mem_req=0, idone=0, count=0, state IDLE, ins_pc=RESET_VEC, fetch address={RESET_VEC[RV-1:2],2'b00}, odd-start flag=RESET_VEC[1].
REQ-029 First mem_req SHALL assert in the first cycle after reset returns to 1.
REQ-030 Reset asserted while a request is outstanding SHALL abandon it; a mem_ack arriving during or after reset for that request is ignored.

Configuration
REQ-031 Macro IFETCH_PREFETCH_EN: defined -> in IDLE, issue request whenever count<=2 (prefetch while decoder consumes).
REQ-032 Undefined -> issue request only in IDLE with count==0; count never exceeds 2; all other behaviour identical.

Verification
REQ-033 Reset release, RESET_VEC=0, ack 1 cycle later with 0x22224111 -> mem_addr=0; idone with ins=0x4111/ins_pc=0 then ins=0x2222/ins_pc=2.
REQ-034 pc_load with pc_new=0x102 -> mem_addr=0x100; only 0xBBBB from rdata 0xBBBBAAAA delivered, ins_pc=0x102, next fetch 0x104.
REQ-035 pc_load=1 in cycle WAIT, ack 2 cycles later -> mem_addr held until ack, that data discarded, next mem_req at the new address.
REQ-036 stall=1 for 5 cycles, acks always 1 cycle, prefetch on -> idone=0, ins stable, count stops at 4, no further mem_req.
REQ-037 ins_pc=0xFFFFFFFE popped -> next ins_pc=0x00000000; fetch address 0xFFFFFFFC -> 0x00000000.
REQ-038 reset=0 during WAIT, ack one cycle later -> no enqueue, idone=0, first post-reset fetch at RESET_VEC.

Source files
------------

// File: rtl/ifetch.sv
// ifetch: instruction fetch unit. Reads 32-bit words from instruction memory
// and presents 16-bit parcels to the decoder through a 4-entry circular queue.
// Build option: define IFETCH_PREFETCH_EN to let the fetcher request the next
// word while the queue still holds up to two parcels. Without it, a word is
// requested only once the queue has drained completely.
module ifetch #(
    parameter int unsigned    RV        = 32,
    parameter logic [RV-1:0]  RESET_VEC = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall,
    input  logic          pc_load,
    input  logic [RV-1:0] pc_new,
    output logic          mem_req,
    output logic [RV-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [31:0]   mem_rdata,
    output logic [15:0]   ins,
    output logic          idone,
    output logic [RV-1:0] ins_pc
);

    localparam int unsigned QD   = 4;
    localparam int unsigned PW   = 16;
    localparam int unsigned DW   = 32;
    localparam int unsigned PTRW = 2;
    localparam int unsigned CW   = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_KILL = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [PTRW-1:0] head_q, head_d;
    logic [PTRW-1:0] tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [RV-1:0]   pc_q, pc_d;
    logic [RV-1:0]   faddr_q, faddr_d;
    logic [RV-1:0]   addr_q, addr_d;
    logic            odd_q, odd_d;

    logic [PW-1:0]   q_mem [QD];

    logic            pop;
    logic            keep;
    logic            room_ok;
    logic [CW-1:0]   enq;
    logic            wr0_en, wr1_en;
    logic [PW-1:0]   wr0_data, wr1_data;
    logic [PTRW-1:0] wr0_idx, wr1_idx;

    // Decoder takes the head parcel unless stalled or being redirected.
    assign pop = reset && (count_q != '0) && !stall && !pc_load;

    // Queue space rule for starting a new word fetch from IDLE.
`ifdef IFETCH_PREFETCH_EN
    assign room_ok = (count_q <= CW'(2));
`else
    assign room_ok = (count_q == '0);
`endif

    assign wr0_idx = tail_q;
    assign wr1_idx = tail_q + PTRW'(1);

    // Next-state: fetch FSM, queue pointers, PC and fetch address.
    always_comb begin
        state_d  = state_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        pc_d     = pc_q;
        faddr_d  = faddr_q;
        addr_d   = addr_q;
        odd_d    = odd_q;
        enq      = '0;
        wr0_en   = 1'b0;
        wr1_en   = 1'b0;
        wr0_data = mem_rdata[PW-1:0];
        wr1_data = mem_rdata[DW-1:PW];
        keep     = (state_q == S_WAIT) && mem_ack && !pc_load;

        case (state_q)
            S_IDLE: begin
                // A redirect flushes the queue, so it always leaves room.
                if (pc_load || room_ok) begin
                    state_d = S_WAIT;
                    addr_d  = pc_load ? (pc_new & ~RV'(3)) : faddr_q;
                end
            end
            S_WAIT: begin
                if (mem_ack) begin
                    state_d = S_IDLE;
                end else if (pc_load) begin
                    state_d = S_KILL;
                end
            end
            S_KILL: begin
                if (mem_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (keep) begin
            wr0_en  = 1'b1;
            faddr_d = faddr_q + RV'(4);
            odd_d   = 1'b0;
            // After an odd-halfword redirect only the upper parcel is wanted.
            if (odd_q) begin
                wr0_data = mem_rdata[DW-1:PW];
                enq      = CW'(1);
            end else begin
                wr1_en = 1'b1;
                enq    = CW'(2);
            end
            tail_d = tail_q + enq[PTRW-1:0];
        end

        if (pop) begin
            head_d = head_q + PTRW'(1);
            pc_d   = pc_q + RV'(2);
        end

        count_d = count_q + enq - CW'(pop);

        // Redirect overrides any pop or enqueue in the same cycle.
        if (pc_load) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            pc_d    = pc_new & ~RV'(1);
            faddr_d = pc_new & ~RV'(3);
            odd_d   = pc_new[1];
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            pc_q    <= RESET_VEC & ~RV'(1);
            faddr_q <= RESET_VEC & ~RV'(3);
            addr_q  <= '0;
            odd_q   <= RESET_VEC[1];
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            pc_q    <= pc_d;
            faddr_q <= faddr_d;
            addr_q  <= addr_d;
            odd_q   <= odd_d;
        end
    end

    // Parcel storage; contents are qualified by count, so no reset needed.
    always_ff @(posedge clk) begin
        if (reset && wr0_en) begin
            q_mem[wr0_idx] <= wr0_data;
        end
        if (reset && wr1_en) begin
            q_mem[wr1_idx] <= wr1_data;
        end
    end

    assign mem_req  = reset && (state_q != S_IDLE);
    assign mem_addr = addr_q;
    assign ins      = q_mem[head_q];
    assign idone    = pop;
    assign ins_pc   = pc_q;

endmodule
